// File: rtl/gpio_demux_sched.sv
// ============================================================================
// gpio_demux_sched: two-requester round-robin arbiter and setup/strobe/hold
// write sequencer for the GPIO output demux. Optional: GPIO_SCHED_READBACK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_demux_sched #(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       port0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       port1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [7:0] gpio_out,
  output logic       sel,
  output logic       latch_a,
  output logic       latch_b,
  output logic       busy
`ifdef GPIO_SCHED_READBACK_EN
  ,
  output logic [7:0] shadow_a,
  output logic [7:0] shadow_b
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST  = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       cap_port, cap_port_nxt;
  logic [7:0] cap_data, cap_data_nxt;
  logic       gnt_id, gnt_id_nxt;
  logic       last_grant, last_grant_nxt;
  logic       who;

  logic [7:0] gpio_out_nxt;
  logic       sel_nxt, latch_a_nxt, latch_b_nxt, ack0_nxt, ack1_nxt, busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      cap_port   <= 1'b0;
      cap_data   <= 8'h00;
      gnt_id     <= 1'b0;
      last_grant <= 1'b1;
      gpio_out   <= 8'h00;
      sel        <= 1'b0;
      latch_a    <= 1'b0;
      latch_b    <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cap_port   <= cap_port_nxt;
      cap_data   <= cap_data_nxt;
      gnt_id     <= gnt_id_nxt;
      last_grant <= last_grant_nxt;
      gpio_out   <= gpio_out_nxt;
      sel        <= sel_nxt;
      latch_a    <= latch_a_nxt;
      latch_b    <= latch_b_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cap_port_nxt   = cap_port;
    cap_data_nxt   = cap_data;
    gnt_id_nxt     = gnt_id;
    last_grant_nxt = last_grant;
    who            = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not granted most recently wins.
          who            = (req0 && req1) ? ~last_grant : req1;
          state_nxt      = ST_DRIVE;
          cnt_nxt        = 4'd0;
          cap_port_nxt   = who ? port1 : port0;
          cap_data_nxt   = who ? data1 : data0;
          gnt_id_nxt     = who;
          last_grant_nxt = who;
        end
      end
      ST_DRIVE: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_STROBE: begin
        state_nxt = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
        cnt_nxt   = 4'd0;
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in step with it.
  always_comb begin
    busy_nxt     = (state_nxt != ST_IDLE);
    gpio_out_nxt = busy_nxt ? cap_data_nxt : 8'h00;
    sel_nxt      = busy_nxt & cap_port_nxt;
    latch_a_nxt  = (state_nxt == ST_STROBE) & ~cap_port_nxt;
    latch_b_nxt  = (state_nxt == ST_STROBE) &  cap_port_nxt;
    ack0_nxt     = (state_nxt == ST_STROBE) & ~gnt_id_nxt;
    ack1_nxt     = (state_nxt == ST_STROBE) &  gnt_id_nxt;
  end

`ifdef GPIO_SCHED_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_a <= 8'h00;
      shadow_b <= 8'h00;
    end else if (state == ST_STROBE) begin
      if (cap_port) shadow_b <= cap_data;
      else          shadow_a <= cap_data;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpio_demux_sched.sv
// Testbench for gpio_demux_sched: directed scenarios plus randomized traffic
// against a transfer-level reference model, on a default and a 3/0 instance.
`default_nettype none

module tb_gpio_demux_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req0, port0, req1, port1;
  logic [1:0][7:0] data0, data1;
  logic [1:0]      ack0, ack1, sel, la, lb, busy;
  logic [1:0][7:0] gout;
`ifdef GPIO_SCHED_READBACK_EN
  logic [1:0][7:0] sha, shb;
`endif

  int checks = 0;
  int errors = 0;

  gpio_demux_sched #(.SETUP_CYCLES(1), .HOLD_CYCLES(1)) u_def (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .port0(port0[0]), .data0(data0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .port1(port1[0]), .data1(data1[0]), .ack1(ack1[0]),
    .gpio_out(gout[0]), .sel(sel[0]), .latch_a(la[0]), .latch_b(lb[0]), .busy(busy[0])
`ifdef GPIO_SCHED_READBACK_EN
    , .shadow_a(sha[0]), .shadow_b(shb[0])
`endif
  );

  gpio_demux_sched #(.SETUP_CYCLES(3), .HOLD_CYCLES(0)) u_s3 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .port0(port0[1]), .data0(data0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .port1(port1[1]), .data1(data1[1]), .ack1(ack1[1]),
    .gpio_out(gout[1]), .sel(sel[1]), .latch_a(la[1]), .latch_b(lb[1]), .busy(busy[1])
`ifdef GPIO_SCHED_READBACK_EN
    , .shadow_a(sha[1]), .shadow_b(shb[1])
`endif
  );

  // Reference model: a transfer is a span of cycles numbered 1..S+1+H after
  // the grant edge; cycle S+1 is the strobe cycle.
  int         S [2] = '{1, 3};
  int         H [2] = '{1, 0};
  bit         m_act [2];
  int         m_e [2];
  bit         m_port [2];
  logic [7:0] m_data [2];
  bit         m_who [2];
  bit         m_last [2];
  logic [7:0] m_sa [2];
  logic [7:0] m_sb [2];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_e[i] = 0; m_last[i] = 1; m_sa[i] = 8'h00; m_sb[i] = 8'h00;
      end else if (m_act[i]) begin
        if (m_e[i] == S[i] + 1) begin
          if (m_port[i]) m_sb[i] = m_data[i];
          else           m_sa[i] = m_data[i];
        end
        m_e[i]++;
        if (m_e[i] > S[i] + 1 + H[i]) m_act[i] = 0;
      end else if (req0[i] || req1[i]) begin
        m_who[i]  = (req0[i] && req1[i]) ? !m_last[i] : bit'(req1[i]);
        m_last[i] = m_who[i];
        m_act[i]  = 1;
        m_e[i]    = 1;
        m_port[i] = m_who[i] ? port1[i] : port0[i];
        m_data[i] = m_who[i] ? data1[i] : data0[i];
      end
    end
  endtask

  task automatic check_model();
    bit st;
    for (int i = 0; i < 2; i++) begin
      st = m_act[i] && (m_e[i] == S[i] + 1);
      chk8($sformatf("model gpio_out u%0d", i), gout[i], m_act[i] ? m_data[i] : 8'h00);
      chk1($sformatf("model sel u%0d", i), sel[i], m_act[i] && m_port[i]);
      chk1($sformatf("model latch_a u%0d", i), la[i], st && !m_port[i]);
      chk1($sformatf("model latch_b u%0d", i), lb[i], st && m_port[i]);
      chk1($sformatf("model ack0 u%0d", i), ack0[i], st && !m_who[i]);
      chk1($sformatf("model ack1 u%0d", i), ack1[i], st && m_who[i]);
      chk1($sformatf("model busy u%0d", i), busy[i], m_act[i]);
`ifdef GPIO_SCHED_READBACK_EN
      chk8($sformatf("model shadow_a u%0d", i), sha[i], m_sa[i]);
      chk8($sformatf("model shadow_b u%0d", i), shb[i], m_sb[i]);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst = 1'b1;
    req0 = '0; port0 = '0; req1 = '0; port1 = '0; data0 = '0; data1 = '0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_e[i] = 0; m_last[i] = 1; m_who[i] = 0; m_port[i] = 0;
      m_data[i] = 8'h00; m_sa[i] = 8'h00; m_sb[i] = 8'h00;
    end
    step(); step();
    chk8("reset gpio_out", gout[0], 8'h00);
    chk1("reset busy", busy[0], 1'b0);
    rst = 1'b0;
    step();

    // Single request to port A.
    req0[0] = 1'b1; port0[0] = 1'b0; data0[0] = 8'hA5;
    step();
    chk8("single c1 gpio_out", gout[0], 8'hA5);
    chk1("single c1 latch_a", la[0], 1'b0);
    step();
    chk1("single c2 latch_a", la[0], 1'b1);
    chk1("single c2 ack0", ack0[0], 1'b1);
    chk1("single c2 latch_b", lb[0], 1'b0);
    req0[0] = 1'b0;
    step();
    chk8("single c3 gpio_out", gout[0], 8'hA5);
    step();
    chk8("single c4 gpio_out", gout[0], 8'h00);
    chk1("single c4 busy", busy[0], 1'b0);

    // Tie from reset, both held: grants alternate 0,1,0,1 every 4 cycles.
    rst = 1'b1;
    req0[0] = 1'b1; port0[0] = 1'b0; data0[0] = 8'h11;
    req1[0] = 1'b1; port1[0] = 1'b1; data1[0] = 8'h22;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk1($sformatf("tie c%0d ack0", c), ack0[0], 1'((c % 8) == 2));
      chk1($sformatf("tie c%0d ack1", c), ack1[0], 1'((c % 8) == 6));
      if (c == 6) chk8("tie c6 gpio_out", gout[0], 8'h22);
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    step(); step(); step();

    // SETUP=3, HOLD=0 instance: port B, back-to-back request pending.
    req0[1] = 1'b1; port0[1] = 1'b1; data0[1] = 8'h3C;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk1($sformatf("s3 c%0d busy", c), busy[1], 1'(c != 5));
      chk1($sformatf("s3 c%0d latch_b", c), lb[1], 1'(c == 4));
      chk8($sformatf("s3 c%0d gpio_out", c), gout[1], (c == 5) ? 8'h00 : 8'h3C);
    end
    req0[1] = 1'b0;
    for (int c = 0; c < 5; c++) step();

    // Data change one cycle after the grant is ignored.
    req1[0] = 1'b1; port1[0] = 1'b0; data1[0] = 8'h55;
    step();
    data1[0] = 8'hFF;
    step();
    chk1("datachg ack1", ack1[0], 1'b1);
    chk8("datachg strobe gpio_out", gout[0], 8'h55);
    req1[0] = 1'b0;
    step();
    chk8("datachg hold gpio_out", gout[0], 8'h55);
    step();

    // Reset during DRIVE: no strobe/ack; pending request re-granted afterwards.
    req0[0] = 1'b1; port0[0] = 1'b1; data0[0] = 8'h5A;
    step();
    rst = 1'b1;
    step();
    chk1("rstmid latch_b", lb[0], 1'b0);
    chk1("rstmid ack0", ack0[0], 1'b0);
    chk8("rstmid gpio_out", gout[0], 8'h00);
    chk1("rstmid busy", busy[0], 1'b0);
    rst = 1'b0;
    step();
    chk1("regrant busy", busy[0], 1'b1);
    chk8("regrant gpio_out", gout[0], 8'h5A);
    step();
    chk1("regrant latch_b", lb[0], 1'b1);
    chk1("regrant ack0", ack0[0], 1'b1);
    req0[0] = 1'b0;
    step(); step();

`ifdef GPIO_SCHED_READBACK_EN
    req0[0] = 1'b1; port0[0] = 1'b0; data0[0] = 8'h81;
    step(); step();
    chk8("rb strobe shadow_a", sha[0], 8'h00);
    req0[0] = 1'b0;
    step();
    chk8("rb after shadow_a", sha[0], 8'h81);
    step();
    req0[0] = 1'b1; port0[0] = 1'b1; data0[0] = 8'h7E;
    step(); step();
    chk8("rb strobe shadow_b", shb[0], 8'h00);
    req0[0] = 1'b0;
    step();
    chk8("rb after shadow_b", shb[0], 8'h7E);
    chk8("rb keep shadow_a", sha[0], 8'h81);
    step();
`endif

    // Randomized traffic, including abandoned requests and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) data0[i] = 8'($urandom);
        if ($urandom_range(3) == 0) data1[i] = 8'($urandom);
        if ($urandom_range(5) == 0) port0[i] = 1'($urandom);
        if ($urandom_range(5) == 0) port1[i] = 1'($urandom);
        req0[i] = ack0[i] ? 1'($urandom_range(3) == 0)
                : req0[i] ? 1'($urandom_range(15) != 0) : 1'($urandom_range(2) == 0);
        req1[i] = ack1[i] ? 1'($urandom_range(3) == 0)
                : req1[i] ? 1'($urandom_range(15) != 0) : 1'($urandom_range(2) == 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
